// File: rtl/mem_arbiter_if.sv
// Bundle of requester and memory-port signals for mem_arbiter.
// Handshake: a requester raises *Req_i with its fields stable and holds them until the
// matching *Valid_o pulse; MemReq_o is held with stable fields until a one-cycle MemAck_i.
interface mem_arbiter_if;
  logic        IReq_i;
  logic [31:0] IAddr_i;
  logic [31:0] IRdata_o;
  logic        IValid_o;
  logic        IStall_o;
  logic        DReq_i;
  logic        DWe_i;
  logic [31:0] DAddr_i;
  logic [7:0]  DWdata_i;
  logic [31:0] DRdata_o;
  logic        DValid_o;
  logic        DStall_o;
  logic        MemReq_o;
  logic        MemWe_o;
  logic [31:0] MemAddr_o;
  logic [31:0] MemWdata_o;
  logic [3:0]  MemByteEn_o;
  logic [31:0] MemRdata_i;
  logic        MemAck_i;

  modport master (
    input  IReq_i, IAddr_i, DReq_i, DWe_i, DAddr_i, DWdata_i, MemRdata_i, MemAck_i,
    output IRdata_o, IValid_o, IStall_o, DRdata_o, DValid_o, DStall_o,
           MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, MemByteEn_o
  );

  modport slave (
    output IReq_i, IAddr_i, DReq_i, DWe_i, DAddr_i, DWdata_i, MemRdata_i, MemAck_i,
    input  IRdata_o, IValid_o, IStall_o, DRdata_o, DValid_o, DStall_o,
           MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, MemByteEn_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported memory: data wins contention unless fetch has
// lost STARVE_LIMIT contended arbitrations in a row. One access in flight at a time.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  mem_arbiter_if.master bus,
  output logic [1:0]   dbg_state  // 0 IDLE, 1 IBUSY, 2 DBUSY, 3 RESP
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [1:0] d_lane;
  logic       fetch_wins;

  assign fetch_wins    = bus.IReq_i && (!bus.DReq_i || starve_cnt == LIMIT);
  assign bus.IStall_o  = bus.IReq_i & ~bus.IValid_o;
  assign bus.DStall_o  = bus.DReq_i & ~bus.DValid_o;
  assign dbg_state     = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= IDLE;
      starve_cnt      <= '0;
      d_lane          <= '0;
      bus.MemReq_o    <= 1'b0;
      bus.MemWe_o     <= 1'b0;
      bus.MemAddr_o   <= '0;
      bus.MemWdata_o  <= '0;
      bus.MemByteEn_o <= '0;
      bus.IRdata_o    <= '0;
      bus.DRdata_o    <= '0;
      bus.IValid_o    <= 1'b0;
      bus.DValid_o    <= 1'b0;
    end else begin
      bus.IValid_o <= 1'b0;
      bus.DValid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fetch_wins) begin
            state           <= IBUSY;
            starve_cnt      <= '0;
            bus.MemReq_o    <= 1'b1;
            bus.MemWe_o     <= 1'b0;
            bus.MemAddr_o   <= {bus.IAddr_i[31:2], 2'b00};
            bus.MemByteEn_o <= 4'hF;
          end else if (bus.DReq_i) begin
            state           <= DBUSY;
            // Fetch lost a contended round; it cannot be at LIMIT here or it would have won.
            if (bus.IReq_i) starve_cnt <= starve_cnt + 4'd1;
            d_lane          <= bus.DAddr_i[1:0];
            bus.MemReq_o    <= 1'b1;
            bus.MemWe_o     <= bus.DWe_i;
            bus.MemAddr_o   <= {bus.DAddr_i[31:2], 2'b00};
            bus.MemWdata_o  <= {4{bus.DWdata_i}};
            bus.MemByteEn_o <= bus.DWe_i ? (4'b0001 << bus.DAddr_i[1:0]) : 4'hF;
          end
        end
        IBUSY: begin
          if (bus.MemAck_i) begin
            state        <= RESP;
            bus.MemReq_o <= 1'b0;
            bus.IRdata_o <= bus.MemRdata_i;
            bus.IValid_o <= 1'b1;
          end
        end
        DBUSY: begin
          if (bus.MemAck_i) begin
            state        <= RESP;
            bus.MemReq_o <= 1'b0;
            if (!bus.MemWe_o) bus.DRdata_o <= {24'b0, bus.MemRdata_i[{d_lane, 3'b000} +: 8]};
            bus.DValid_o <= 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: directed scenarios, starvation contention and
// randomized concurrent traffic against a reference memory and arbitration model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [1:0] dbg_state;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] i_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] ref_mem[1024];
  logic [31:0] dev_mem[1024];
  logic [31:0] d_last;
  bit          mem_auto;
  int          fixed_lat;
  int          starve_m;
  bit          log_en;
  string       glog;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none t=%0t", name, $time);
  endtask

  // Memory device: random or fixed ack latency, byte-enabled writes into dev_mem.
  initial begin
    bit          active;
    int          wl;
    logic [9:0]  w;
    active = 1'b0;
    wl = 0;
    bus.MemAck_i = 1'b0;
    bus.MemRdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (!mem_auto) begin active = 1'b0; continue; end
      bus.MemAck_i = 1'b0;
      if (!rst_n_i || !bus.MemReq_o) begin active = 1'b0; continue; end
      if (!active) begin
        active = 1'b1;
        wl = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
      if (wl == 0) begin
        w = bus.MemAddr_o[11:2];
        if (bus.MemWe_o)
          for (int b = 0; b < 4; b++)
            if (bus.MemByteEn_o[b]) dev_mem[w][8*b +: 8] = bus.MemWdata_o[8*b +: 8];
        bus.MemRdata_i = bus.MemWe_o ? $urandom : dev_mem[w];
        bus.MemAck_i = 1'b1;
        active = 1'b0;
      end else begin
        wl--;
      end
    end
  end

  // Response monitor: pops expected read data on each Valid pulse, checks stalls.
  initial begin
    forever begin
      @(negedge clk_i);
      chk("i_stall", 32'(bus.IStall_o), 32'(bus.IValid_o ? 1'b0 : bus.IReq_i));
      chk("d_stall", 32'(bus.DStall_o), 32'(bus.DValid_o ? 1'b0 : bus.DReq_i));
      if (bus.IValid_o) begin
        if (i_exp_q.size() == 0) fail_event("i_valid_unexpected");
        else chk("i_rdata", bus.IRdata_o, i_exp_q.pop_front());
      end
      if (bus.DValid_o) begin
        if (d_exp_q.size() == 0) fail_event("d_valid_unexpected");
        else chk("d_rdata", bus.DRdata_o, d_exp_q.pop_front());
      end
    end
  end

  // Grant monitor: on each new memory request, decides the rightful winner from the
  // requests present at the arbitration edge and the starvation rule.
  initial begin
    logic       s_i, s_d, prev_req;
    bit         exp_d, got_d;
    logic [3:0] be;
    prev_req = 1'b0;
    starve_m = 0;
    forever begin
      @(posedge clk_i);
      s_i = bus.IReq_i;
      s_d = bus.DReq_i;
      @(negedge clk_i);
      if (!rst_n_i) begin starve_m = 0; prev_req = 1'b0; continue; end
      if (bus.MemReq_o && !prev_req) begin
        if (!s_i && !s_d) begin
          fail_event("spurious_grant");
        end else begin
          exp_d = s_d && !(s_i && starve_m == STARVE_LIMIT);
          got_d = (bus.MemAddr_o >= 32'h200);
          chk("grant_winner", 32'(got_d), 32'(exp_d));
          if (exp_d) begin
            if (s_i) starve_m = (starve_m + 1 > STARVE_LIMIT) ? STARVE_LIMIT : starve_m + 1;
            be = 4'b0001;
            be = bus.DWe_i ? (be << bus.DAddr_i[1:0]) : 4'hF;
            chk("d_mem_addr", bus.MemAddr_o, {bus.DAddr_i[31:2], 2'b00});
            chk("d_mem_we", 32'(bus.MemWe_o), 32'(bus.DWe_i));
            chk("d_mem_be", 32'(bus.MemByteEn_o), 32'(be));
            if (bus.DWe_i) chk("d_mem_wdata", bus.MemWdata_o, {4{bus.DWdata_i}});
          end else begin
            starve_m = 0;
            chk("i_mem_addr", bus.MemAddr_o, {bus.IAddr_i[31:2], 2'b00});
            chk("i_mem_we", 32'(bus.MemWe_o), 32'd0);
            chk("i_mem_be", 32'(bus.MemByteEn_o), 32'hF);
          end
          if (log_en) glog = {glog, got_d ? "D" : "I"};
        end
      end
      prev_req = bus.MemReq_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(input bit is_d);
    int n;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (!(is_d ? bus.DValid_o : bus.IValid_o) && n < 200);
    if (!(is_d ? bus.DValid_o : bus.IValid_o)) fail_event(is_d ? "d_valid_timeout" : "i_valid_timeout");
  endtask

  task automatic fetch_txn(input logic [31:0] addr);
    bus.IReq_i  = 1'b1;
    bus.IAddr_i = addr;
    i_exp_q.push_back(ref_mem[addr[11:2]]);
    wait_valid(1'b0);
    @(posedge clk_i); #1;
  endtask

  task automatic data_txn(input bit we, input logic [31:0] addr, input logic [7:0] wd);
    bus.DReq_i   = 1'b1;
    bus.DWe_i    = we;
    bus.DAddr_i  = addr;
    bus.DWdata_i = wd;
    if (we) ref_mem[addr[11:2]][8*addr[1:0] +: 8] = wd;
    else    d_last = {24'b0, ref_mem[addr[11:2]][8*addr[1:0] +: 8]};
    d_exp_q.push_back(d_last);
    wait_valid(1'b1);
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    bus.IReq_i = 1'b0;
    bus.DReq_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    d_last = '0;
    i_exp_q.delete();
    d_exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_memreq"}, 32'(bus.MemReq_o), 32'd0);
    chk({tag, "_memwe"}, 32'(bus.MemWe_o), 32'd0);
    chk({tag, "_memaddr"}, bus.MemAddr_o, 32'd0);
    chk({tag, "_memwdata"}, bus.MemWdata_o, 32'd0);
    chk({tag, "_membe"}, 32'(bus.MemByteEn_o), 32'd0);
    chk({tag, "_irdata"}, bus.IRdata_o, 32'd0);
    chk({tag, "_drdata"}, bus.DRdata_o, 32'd0);
    chk({tag, "_ivalid"}, 32'(bus.IValid_o), 32'd0);
    chk({tag, "_dvalid"}, 32'(bus.DValid_o), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    for (int w = 0; w < 1024; w++) begin
      dev_mem[w] = $urandom;
      ref_mem[w] = dev_mem[w];
    end
    dev_mem[32'h104 >> 2] = 32'h00A00093;
    ref_mem[32'h104 >> 2] = 32'h00A00093;
    dev_mem[32'h200 >> 2] = 32'hAB123456;
    ref_mem[32'h200 >> 2] = 32'hAB123456;
    mem_auto = 1'b1;
    fixed_lat = -1;
    log_en = 1'b0;
    glog = "";
    d_last = '0;
    bus.IReq_i = 1'b0;
    bus.IAddr_i = '0;
    bus.DReq_i = 1'b0;
    bus.DWe_i = 1'b0;
    bus.DAddr_i = '0;
    bus.DWdata_i = '0;
    rst_n_i = 1'b1;
    #2 rst_n_i = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk_i); @(posedge clk_i); #1 rst_n_i = 1'b1;

    // Fetch with two wait cycles, lbu, sb, and a readback of the stored byte.
    fixed_lat = 2;
    fetch_txn(32'h104);
    bus.IReq_i = 1'b0;
    data_txn(1'b0, 32'h203, 8'h00);
    data_txn(1'b1, 32'h301, 8'h5C);
    bus.DReq_i = 1'b0;
    fixed_lat = -1;
    data_txn(1'b0, 32'h301, 8'h00);
    bus.DReq_i = 1'b0;

    // Immediate ack with request held through RESP: no reissue until IDLE.
    fixed_lat = 0;
    bus.IReq_i = 1'b1;
    bus.IAddr_i = 32'h104;
    i_exp_q.push_back(ref_mem[32'h104 >> 2]);
    i_exp_q.push_back(ref_mem[32'h104 >> 2]);
    @(posedge clk_i); #1;
    chk("fast_c1_memreq", 32'(bus.MemReq_o), 32'd1);
    chk("fast_c1_ivalid", 32'(bus.IValid_o), 32'd0);
    @(posedge clk_i); #1;
    chk("fast_c2_memreq", 32'(bus.MemReq_o), 32'd0);
    chk("fast_c2_ivalid", 32'(bus.IValid_o), 32'd1);
    @(posedge clk_i); #1;
    chk("fast_c3_memreq", 32'(bus.MemReq_o), 32'd0);
    chk("fast_c3_ivalid", 32'(bus.IValid_o), 32'd0);
    @(posedge clk_i); #1;
    chk("fast_c4_memreq", 32'(bus.MemReq_o), 32'd1);
    @(posedge clk_i); #1;
    chk("fast_c5_ivalid", 32'(bus.IValid_o), 32'd1);
    @(posedge clk_i); #1;
    bus.IReq_i = 1'b0;
    fixed_lat = -1;

    // Reset while a load is in DBUSY; a later stray ack must be ignored.
    mem_auto = 1'b0;
    bus.MemAck_i = 1'b0;
    bus.DReq_i = 1'b1;
    bus.DWe_i = 1'b0;
    bus.DAddr_i = 32'h210;
    @(posedge clk_i); #1;
    chk("rst_mid_memreq_before", 32'(bus.MemReq_o), 32'd1);
    chk("rst_mid_state_before", 32'(dbg_state), 32'd2);
    #2 rst_n_i = 1'b0;
    #1 check_all_zero("rst_mid");
    bus.DReq_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1 rst_n_i = 1'b1;
    d_last = '0;
    @(posedge clk_i); #1;
    bus.MemRdata_i = 32'hFFFF_FFFF;
    bus.MemAck_i = 1'b1;
    @(posedge clk_i); #1;
    bus.MemAck_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      chk("stray_ack_dvalid", 32'(bus.DValid_o), 32'd0);
      chk("stray_ack_memreq", 32'(bus.MemReq_o), 32'd0);
      chk("stray_ack_drdata", bus.DRdata_o, 32'd0);
      chk("stray_ack_state", 32'(dbg_state), 32'd0);
    end
    mem_auto = 1'b1;

    // Continuous contention from a clean starvation count.
    do_reset();
    glog = "";
    log_en = 1'b1;
    fork
      begin
        repeat (8) data_txn(1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 511)),
                            8'($urandom));
        bus.DReq_i = 1'b0;
      end
      begin
        repeat (2) fetch_txn({22'b0, 8'($urandom_range(0, 63)), 2'($urandom)});
        bus.IReq_i = 1'b0;
      end
    join
    log_en = 1'b0;
    checks++;
    if (glog != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL grant_order actual=%s expected=DDDDIDDDDI", glog);
    end

    // Randomized concurrent traffic with random gaps and latencies.
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          int gap;
          fetch_txn({22'b0, 8'($urandom_range(0, 63)), 2'($urandom)});
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            bus.IReq_i = 1'b0;
            repeat (gap) @(posedge clk_i);
            #1;
          end
        end
        bus.IReq_i = 1'b0;
      end
      begin
        for (int n = 0; n < 30; n++) begin
          int gap;
          data_txn(1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 511)), 8'($urandom));
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            bus.DReq_i = 1'b0;
            repeat (gap) @(posedge clk_i);
            #1;
          end
        end
        bus.DReq_i = 1'b0;
      end
    join

    repeat (5) @(posedge clk_i);
    #1;
    chk("i_queue_drained", 32'(i_exp_q.size()), 32'd0);
    chk("d_queue_drained", 32'(d_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the CPU's single-ported unified memory. Sits between the instruction-fetch stage and the data-access stage (lbu loads, sb stores) on one side and the memory port on the other. Grants one access at a time, handles byte-lane steering for data accesses, and drives per-requester stall signals into the pipeline. Data accesses take priority, with a starvation guard for fetch.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive contended data grants after which fetch wins the next contended arbitration (1..15).

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- IReq_i  in  1  fetch request; held with IAddr_i stable until IValid_o
- IAddr_i  in  32  fetch address; bits [1:0] ignored
- IRdata_o  out  32  fetched instruction word
- IValid_o  out  1  one-cycle fetch completion pulse
- IStall_o  out  1  IReq_i & ~IValid_o
- DReq_i  in  1  data request; held with DWe_i/DAddr_i/DWdata_i stable until DValid_o
- DWe_i  in  1  1 = sb store, 0 = lbu load
- DAddr_i  in  32  byte address
- DWdata_i  in  8  store byte
- DRdata_o  out  32  load byte, zero-extended
- DValid_o  out  1  one-cycle data completion pulse (loads and stores)
- DStall_o  out  1  DReq_i & ~DValid_o
- MemReq_o  out  1  memory request; held until MemAck_i
- MemWe_o  out  1  write enable
- MemAddr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- MemWdata_o  out  32  write data
- MemByteEn_o  out  4  byte enables
- MemRdata_i  in  32  read data, valid in the MemAck_i cycle
- MemAck_i  in  1  one-cycle completion from memory

## Operation
- States: IDLE, IBUSY, DBUSY, RESP.
- IDLE: no request -> stay. DReq_i only -> DBUSY. IReq_i only -> IBUSY. Both -> DBUSY, unless starve_cnt == STARVE_LIMIT, then IBUSY.
- starve_cnt (4 bits): +1 on each data grant while IReq_i is high, saturating at STARVE_LIMIT. Cleared on every fetch grant. Unchanged on an uncontended data grant.
- On grant, register the memory-side outputs from the winner:
  - Fetch: We=0, ByteEn=4'b1111.
  - Load: We=0, ByteEn=4'b1111.
  - Store: We=1, Wdata={4{DWdata_i}}, ByteEn=4'b0001<<DAddr_i[1:0].
- IBUSY/DBUSY: MemReq_o=1, memory outputs stable. Each cycle without MemAck_i -> stay. On MemAck_i -> RESP:
  - Fetch: capture IRdata_o <= MemRdata_i.
  - Load: capture DRdata_o <= {24'b0, byte DAddr[1:0] of MemRdata_i}.
  - Store: DRdata_o unchanged.
- RESP: pulse the matching Valid_o for exactly one cycle. Requests are ignored in this state. RESP -> IDLE unconditionally.
- MemAck_i in IDLE or RESP is ignored.
- IRdata_o/DRdata_o hold their values until the next completion of the same kind.

## Timing
- Reset (async, immediate): state=IDLE, starve_cnt=0, all outputs 0, including MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, MemByteEn_o, IRdata_o, DRdata_o, IValid_o, DValid_o.
- Reset mid-access: MemReq_o drops immediately and the access is abandoned. A later stray MemAck_i is ignored.
- Request sampled in IDLE at cycle 0 -> MemReq_o high from cycle 1.
  - Memory may ack in cycle 1 at the earliest.
  - Ack in cycle k -> Valid_o high in cycle k+1 -> IDLE in cycle k+2, when the next request can be sampled.
  - Minimum access: 3 cycles request-to-valid-plus-one. Peak throughput: one access per 3 cycles.
- Stall outputs are combinational from Req inputs and registered Valid outputs, with no extra latency.
- Requester deasserts or changes its request no earlier than the edge ending the Valid_o cycle.
- Request inputs are never sampled outside IDLE, so a held request cannot be double-issued.

## Test plan
- Fetch only: IReq_i=1, IAddr_i=0x104; memory acks after 2 wait cycles with 0x00A00093 -> MemAddr_o=0x104, MemByteEn_o=4'hF, IRdata_o=0x00A00093, IValid_o pulses once, IStall_o low in that cycle.
- lbu: DAddr_i=0x203, memory returns 0xAB123456 -> MemAddr_o=0x200, DRdata_o=0x000000AB, DValid_o single pulse.
- sb: DAddr_i=0x301, DWdata_i=0x5C -> MemWe_o=1, MemAddr_o=0x300, MemWdata_o=0x5C5C5C5C, MemByteEn_o=4'b0010.
- Contention with STARVE_LIMIT=4, both requests held continuously -> grant order D,D,D,D,I,D,D,D,D,I; counter clears on each I grant.
- Assert rst_n_i low while in DBUSY, then send MemAck_i after reset release -> all outputs 0 immediately; ack ignored; no Valid_o pulse; state IDLE.
- Immediate ack in the first MemReq_o cycle -> Valid_o exactly 2 cycles after request sampling; request still held during RESP -> no second MemReq_o until IDLE.
